// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice as an N-term multiply-accumulate engine.
// Operand pairs are registered onto dsp_a/dsp_b and a {valid, first} token is shifted
// alongside them so the P clock enable and OPMODE line up with the product at the post-adder.
module dsp_mac_sequencer #(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] dsp_a,
  output logic [WIDTH-1:0] dsp_b,
  output logic             dsp_ce_ab,
  output logic             dsp_ce_p,
  output logic [7:0]       dsp_opmode,
  output logic             done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StFin   = 3'd3;
  localparam logic [2:0] StZero  = 3'd4;

  localparam logic [LEN_W-1:0] CntOne  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CntZero = '0;

  // X=M, Z=0 loads P with the product; X=M, Z=P accumulates.
  localparam logic [7:0] OpLoad  = 8'h01;
  localparam logic [7:0] OpAccum = 8'h09;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_in_q, cnt_in_d;
  logic [LEN_W-1:0] cnt_out_q, cnt_out_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Token delay line: stage 0 is aligned with dsp_a/dsp_b, stage PIPE_LAT with the post-adder.
  logic [PIPE_LAT:0] v_q, v_d;
  logic [PIPE_LAT:0] f_q, f_d;

  logic hs;
  logic tok;
  logic tok_first;

  // Output decode from state and the last token stage.
  always_comb begin
    busy       = (state_q == StRun) || (state_q == StDrain) || (state_q == StZero);
    in_ready   = (state_q == StRun);
    done       = (state_q == StFin) || (state_q == StZero);
    hs         = in_valid && in_ready;
    tok        = v_q[PIPE_LAT];
    tok_first  = f_q[PIPE_LAT];
    dsp_ce_ab  = busy;
    dsp_ce_p   = busy && tok;
    dsp_opmode = 8'h00;
    if (busy) begin
      dsp_opmode = (tok && tok_first) ? OpLoad : OpAccum;
    end
    dsp_a = a_q;
    dsp_b = b_q;
  end

  // Next-state: FSM, term counters, operand capture and token shift.
  always_comb begin
    state_d   = state_q;
    cnt_in_d  = cnt_in_q;
    cnt_out_d = cnt_out_q;
    len_d     = len_q;
    a_d       = a_q;
    b_d       = b_q;
    v_d       = v_q;
    f_d       = f_q;

    if (hs) begin
      a_d = in_a;
      b_d = in_b;
    end

    // Free-running shift while busy; a cycle without a handshake inserts a bubble.
    if (busy) begin
      for (int i = PIPE_LAT; i > 0; i--) begin
        v_d[i] = v_q[i-1];
        f_d[i] = f_q[i-1];
      end
      v_d[0] = hs;
      f_d[0] = hs && (cnt_in_q == len_q);
    end

    if (busy && tok) begin
      cnt_out_d = cnt_out_q - CntOne;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          if (len != CntZero) begin
            state_d   = StRun;
            cnt_in_d  = len;
            cnt_out_d = len;
            len_d     = len;
          end else begin
            state_d = StZero;
          end
        end
      end
      StRun: begin
        if (hs) begin
          cnt_in_d = cnt_in_q - CntOne;
          if (cnt_in_q == CntOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave on the cycle P captures the final product so done follows it directly.
        if (cnt_out_d == CntZero) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      StZero:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
      len_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      v_q       <= '0;
      f_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_in_q  <= cnt_in_d;
      cnt_out_q <= cnt_out_d;
      len_q     <= len_d;
      a_q       <= a_d;
      b_q       <= b_d;
      v_q       <= v_d;
      f_q       <= f_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice (AREG/BREG, MREG, PREG).
module tb_dsp_mac_sequencer;

  localparam int unsigned WIDTH    = 18;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned PIPE_LAT = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] dsp_a;
  logic [WIDTH-1:0] dsp_b;
  logic             dsp_ce_ab;
  logic             dsp_ce_p;
  logic [7:0]       dsp_opmode;
  logic             done;

  int total = 0;
  int bad   = 0;

  dsp_mac_sequencer #(
    .WIDTH   (WIDTH),
    .LEN_W   (LEN_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_ce_ab (dsp_ce_ab),
    .dsp_ce_p  (dsp_ce_p),
    .dsp_opmode(dsp_opmode),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice: A/B register then M register (PIPE_LAT=2), P register as accumulator.
  logic [WIDTH-1:0]   s_a, s_b;
  logic [2*WIDTH-1:0] s_m;
  logic [47:0]        s_p;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a <= '0;
      s_b <= '0;
      s_m <= '0;
      s_p <= '0;
    end else begin
      if (dsp_ce_ab) begin
        s_a <= dsp_a;
        s_b <= dsp_b;
        s_m <= s_a * s_b;
      end
      if (dsp_ce_p) begin
        s_p <= (dsp_opmode[3] ? s_p : 48'd0) + (dsp_opmode[1:0] == 2'b01 ? 48'(s_m) : 48'd0);
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  int         cyc = 0;
  int         cep_cnt = 0;
  int         done_cnt = 0;
  int         bubble_bad = 0;
  int         last_hs_cyc = 0;
  int         done_cyc = 0;
  logic [7:0] opq[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dsp_ce_p) begin
      cep_cnt = cep_cnt + 1;
      opq.push_back(dsp_opmode);
    end
    if (busy && !dsp_ce_p && dsp_opmode !== 8'h09) bubble_bad = bubble_bad + 1;
    if (in_valid && in_ready) last_hs_cyc = cyc;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cep_cnt    = 0;
    done_cnt   = 0;
    bubble_bad = 0;
    opq.delete();
  endtask

  task automatic kick(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic pair(input int a, input int b);
    in_valid = 1'b1;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    tick();
    in_valid = 1'b0;
  endtask

  // Returns with done visible (the FIN cycle), or ok=0 after the cycle budget.
  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    total++;
    if ({busy, in_ready, dsp_ce_ab, dsp_ce_p, done} !== 5'b0 || dsp_a !== '0 || dsp_b !== '0 ||
        dsp_opmode !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b rdy=%b ceab=%b cep=%b done=%b a=%0d b=%0d op=%h want all 0",
               busy, in_ready, dsp_ce_ab, dsp_ce_p, done, dsp_a, dsp_b, dsp_opmode);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    kick(4);
    pair(1, 2);
    pair(3, 4);
    pair(5, 6);
    pair(7, 8);
    wait_done(20, ok);
    tick();
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_done_timeout got done=%b want 1", done);
    end
    total++;
    if (cep_cnt != 4) begin
      bad++;
      $display("FAIL basic_cep_count got %0d want 4", cep_cnt);
    end
    total++;
    if (opq.size() != 4 || opq[0] !== 8'h01 || opq[1] !== 8'h09 || opq[2] !== 8'h09 ||
        opq[3] !== 8'h09) begin
      bad++;
      $display("FAIL basic_opmode_seq got n=%0d %h %h %h %h want 01 09 09 09",
               opq.size(), opq[0], opq[1], opq[2], opq[3]);
    end
    total++;
    if (done_cyc - last_hs_cyc != PIPE_LAT + 2) begin
      bad++;
      $display("FAIL basic_latency got %0d want %0d", done_cyc - last_hs_cyc, PIPE_LAT + 2);
    end
    total++;
    if (s_p !== 48'd100) begin
      bad++;
      $display("FAIL basic_sum got %0d want 100", s_p);
    end
    total++;
    if (dsp_a !== 18'd7 || dsp_b !== 18'd8 || done_cnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_tail got a=%0d b=%0d dones=%0d busy=%b want 7 8 1 0",
               dsp_a, dsp_b, done_cnt, busy);
    end
  endtask

  task automatic test_bubbles();
    bit ok;
    clear_mon();
    kick(3);
    pair(2, 3);
    tick();
    tick();
    pair(4, 5);
    tick();
    tick();
    pair(6, 7);
    wait_done(20, ok);
    tick();
    total++;
    if (!ok || done_cnt != 1) begin
      bad++;
      $display("FAIL bubbles_done got ok=%b dones=%0d want 1 1", ok, done_cnt);
    end
    total++;
    if (cep_cnt != 3 || opq.size() != 3 || opq[0] !== 8'h01 || opq[1] !== 8'h09 ||
        opq[2] !== 8'h09) begin
      bad++;
      $display("FAIL bubbles_cep got n=%0d ops %h %h %h want 3 01 09 09",
               cep_cnt, opq[0], opq[1], opq[2]);
    end
    total++;
    if (bubble_bad != 0) begin
      bad++;
      $display("FAIL bubbles_opmode got %0d non-09 bubble cycles want 0", bubble_bad);
    end
    total++;
    if (s_p !== 48'd68) begin
      bad++;
      $display("FAIL bubbles_sum got %0d want 68", s_p);
    end
  endtask

  task automatic test_zero_len();
    logic [47:0] p_before;
    clear_mon();
    p_before = s_p;
    kick(0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || dsp_ce_p !== 1'b0) begin
      bad++;
      $display("FAIL zero_pulse got done=%b busy=%b cep=%b want 1 1 0", done, busy, dsp_ce_p);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy);
    end
    tick();
    total++;
    if (cep_cnt != 0 || done_cnt != 1 || s_p !== p_before) begin
      bad++;
      $display("FAIL zero_effects got ceps=%0d dones=%0d p=%0d want 0 1 %0d",
               cep_cnt, done_cnt, s_p, p_before);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    kick(2);
    pair(2, 3);
    pair(4, 5);
    wait_done(20, ok);
    total++;
    if (!ok || s_p !== 48'd26) begin
      bad++;
      $display("FAIL b2b_job1 got ok=%b p=%0d want 1 26", ok, s_p);
    end
    // Start raised in the FIN cycle must be dropped.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_fin_start got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    clear_mon();
    kick(2);
    pair(1, 1);
    pair(1, 1);
    wait_done(20, ok);
    tick();
    total++;
    if (!ok || opq.size() != 2 || opq[0] !== 8'h01 || opq[1] !== 8'h09) begin
      bad++;
      $display("FAIL b2b_job2_ops got ok=%b n=%0d %h %h want 1 2 01 09",
               ok, opq.size(), opq[0], opq[1]);
    end
    total++;
    if (s_p !== 48'd2) begin
      bad++;
      $display("FAIL b2b_job2_sum got %0d want 2", s_p);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    clear_mon();
    kick(5);
    pair(3, 3);
    pair(4, 4);
    in_valid = 1'b1;
    in_a     = 18'd99;
    in_b     = 18'd99;
    rst      = 1'b1;
    #1;
    total++;
    if ({busy, in_ready, dsp_ce_ab, dsp_ce_p, done} !== 5'b0 || dsp_a !== '0 || dsp_b !== '0 ||
        dsp_opmode !== 8'h00) begin
      bad++;
      $display("FAIL midrst_outputs got busy=%b rdy=%b ceab=%b cep=%b done=%b a=%0d b=%0d op=%h want 0",
               busy, in_ready, dsp_ce_ab, dsp_ce_p, done, dsp_a, dsp_b, dsp_opmode);
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle got dones=%0d busy=%b want 0 0", done_cnt, busy);
    end
    clear_mon();
    kick(1);
    pair(9, 9);
    wait_done(20, ok);
    tick();
    total++;
    if (!ok || cep_cnt != 1 || opq[0] !== 8'h01 || s_p !== 48'd81) begin
      bad++;
      $display("FAIL midrst_recover got ok=%b ceps=%0d op=%h p=%0d want 1 1 01 81",
               ok, cep_cnt, opq[0], s_p);
    end
  endtask

  task automatic test_full_len();
    bit ok;
    int loads = 0;
    clear_mon();
    kick(255);
    for (int i = 0; i < 255; i++) begin
      in_valid = 1'b1;
      in_a     = 18'd2;
      in_b     = 18'd3;
      start    = (i == 10) || (i == 11);
      len      = 8'd3;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    wait_done(50, ok);
    tick();
    tick();
    foreach (opq[i]) if (opq[i] == 8'h01) loads++;
    total++;
    if (!ok || done_cnt != 1) begin
      bad++;
      $display("FAIL full_done got ok=%b dones=%0d want 1 1", ok, done_cnt);
    end
    total++;
    if (cep_cnt != 255 || loads != 1) begin
      bad++;
      $display("FAIL full_cep got ceps=%0d loads=%0d want 255 1", cep_cnt, loads);
    end
    total++;
    if (s_p !== 48'd1530 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_sum got p=%0d busy=%b want 1530 0", s_p, busy);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #12;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_job();
    test_full_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
